decode_stage: RTL and testbench

//  Registered, parametrised instruction-decode pipeline stage between fetch and execute. It splits
//  the instruction into fields, sign- or zero-extends the immediate and generates control flags.
//  A register scoreboard stalls on RAW/WAW hazards. Valid/ready handshake on both sides.

---
 rtl/decode_pkg.sv | 50 +++++
 rtl/decode_scoreboard.sv | 55 +++++
 rtl/decode_stage.sv | 149 ++++++++++++++
 tb/tb_decode_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode encodings, control-bit positions
// and the immediate-extension / control-ROM helpers.
package decode_pkg;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_ADD  = 4'h1;
   localparam logic [3:0] OPC_SUB  = 4'h2;
   localparam logic [3:0] OPC_AND  = 4'h3;
   localparam logic [3:0] OPC_OR   = 4'h4;
   localparam logic [3:0] OPC_XOR  = 4'h5;
   localparam logic [3:0] OPC_ADDI = 4'h6;
   localparam logic [3:0] OPC_LDI  = 4'h7;
   localparam logic [3:0] OPC_LD   = 4'h8;
   localparam logic [3:0] OPC_ST   = 4'h9;
   localparam logic [3:0] OPC_BEQ  = 4'hA;
   localparam logic [3:0] OPC_JMP  = 4'hB;
   localparam logic [3:0] OPC_HALT = 4'hF;

   localparam int CTRL_W         = 6;
   localparam int CTRL_REG_WRITE = 5;
   localparam int CTRL_USES_RS1  = 4;
   localparam int CTRL_USES_RS2  = 3;
   localparam int CTRL_IS_IMM    = 2;
   localparam int CTRL_IS_BRANCH = 1;
   localparam int CTRL_ILLEGAL   = 0;

   function automatic logic [63:0] ext_imm(input logic [63:0] imm, input int imm_w,
                                           input logic sext);
      logic [63:0] mask;
      logic        sign;
      mask = ~(~64'd0 << imm_w);
      sign = sext & (|((imm >> (imm_w - 1)) & 64'd1));
      return sign ? (imm | ~mask) : (imm & mask);
   endfunction

   // Bit order {reg_write, uses_rs1, uses_rs2, is_imm, is_branch, illegal}.
   function automatic logic [CTRL_W-1:0] ctrl_rom(input logic [3:0] opc);
      case (opc)
         OPC_NOP, OPC_HALT:                        return 6'b000000;
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: return 6'b111000;
         OPC_ADDI, OPC_LD:                         return 6'b110100;
         OPC_LDI:                                  return 6'b100100;
         OPC_ST:                                   return 6'b011100;
         OPC_BEQ:                                  return 6'b011110;
         OPC_JMP:                                  return 6'b000110;
         default:                                  return 6'b000001;
      endcase
   endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy tracker: set when a writing bundle issues, cleared by writeback,
// and answers "blocked" queries including the bundle still sitting in the output register.
module decode_scoreboard
   import decode_pkg::*;
#(
   parameter int REG_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_rd,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_rd,
   input  logic             pend_en,
   input  logic [REG_W-1:0] pend_rd,
   input  logic [REG_W-1:0] q_rs1,
   input  logic [REG_W-1:0] q_rs2,
   input  logic [REG_W-1:0] q_rd,
   output logic             blk_rs1,
   output logic             blk_rs2,
   output logic             blk_rd
);

   localparam int NREG = 2 ** REG_W;

   logic [NREG-1:0] busy_d, busy_q;
   logic [NREG-1:0] set_mask_s, clr_mask_s, pend_mask_s, blocked_s;

   // Decode set/clear/pending masks; set is applied after clear so it wins.
   always_comb begin
      set_mask_s  = {NREG{1'b0}};
      clr_mask_s  = {NREG{1'b0}};
      pend_mask_s = {NREG{1'b0}};
      if (set_en) set_mask_s[set_rd] = 1'b1;
      else        set_mask_s = {NREG{1'b0}};
      if (clr_en) clr_mask_s[clr_rd] = 1'b1;
      else        clr_mask_s = {NREG{1'b0}};
      if (pend_en) pend_mask_s[pend_rd] = 1'b1;
      else         pend_mask_s = {NREG{1'b0}};
      busy_d    = (busy_q & ~clr_mask_s) | set_mask_s;
      // Same-cycle writeback bypasses the busy bit.
      blocked_s = (busy_q & ~clr_mask_s) | pend_mask_s;
   end

   assign blk_rs1 = blocked_s[q_rs1];
   assign blk_rs2 = blocked_s[q_rs2];
   assign blk_rd  = blocked_s[q_rd];

   // Busy vector register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= {NREG{1'b0}};
      else        busy_q <= busy_d;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split, immediate extension, control ROM,
// scoreboard hazard stall and a single valid/ready output register.
module decode_stage
   import decode_pkg::*;
#(
   parameter int INSTR_W  = 16,
   parameter int OPC_W    = 4,
   parameter int REG_W    = 2,
   parameter int IMM_W    = 8,
   parameter int DATA_W   = 16,
   parameter int IMM_SEXT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OPC_W-1:0]   out_opcode,
   output logic [REG_W-1:0]   out_rd,
   output logic [REG_W-1:0]   out_rs1,
   output logic [REG_W-1:0]   out_rs2,
   output logic [DATA_W-1:0]  out_imm,
   output logic [CTRL_W-1:0]  out_ctrl,
   input  logic               wb_valid,
   input  logic [REG_W-1:0]   wb_rd,
   input  logic               flush,
   output logic               halted
);

   if (INSTR_W < OPC_W + 3 * REG_W || IMM_W > INSTR_W - OPC_W - REG_W ||
       DATA_W < IMM_W || DATA_W > 64 || OPC_W < 4) begin : g_bad_params
      $error("decode_stage: illegal parameter combination");
   end

   logic [OPC_W-1:0]  opc_s;
   logic [31:0]       opc_wide_s;
   logic [REG_W-1:0]  rd_s, rs1_s, rs2_s;
   logic [IMM_W-1:0]  imm_raw_s;
   logic [DATA_W-1:0] imm_s;
   logic [CTRL_W-1:0] ctrl_s;
   logic              is_halt_s, hazard_s, in_ready_s, accept_s;
   logic              blk_rs1_s, blk_rs2_s, blk_rd_s, busy_set_s;

   logic               out_valid_d, out_valid_q, halted_d, halted_q;
   logic [OPC_W-1:0]   out_opcode_d, out_opcode_q;
   logic [REG_W-1:0]   out_rd_d, out_rd_q, out_rs1_d, out_rs1_q, out_rs2_d, out_rs2_q;
   logic [DATA_W-1:0]  out_imm_d, out_imm_q;
   logic [CTRL_W-1:0]  out_ctrl_d, out_ctrl_q;

   assign opc_s     = in_instr[INSTR_W-1 -: OPC_W];
   assign rd_s      = in_instr[INSTR_W-OPC_W-1 -: REG_W];
   assign rs1_s     = in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
   assign rs2_s     = in_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
   assign imm_raw_s = in_instr[IMM_W-1:0];
   assign imm_s     = DATA_W'(ext_imm(64'(imm_raw_s), IMM_W, IMM_SEXT != 0));

   // Control ROM; opcodes beyond 4'hF only exist for wider OPC_W and are illegal.
   always_comb begin
      opc_wide_s = 32'(opc_s);
      if (opc_wide_s > 32'd15) ctrl_s = 6'b000001;
      else                     ctrl_s = ctrl_rom(opc_wide_s[3:0]);
   end
   assign is_halt_s = (opc_wide_s == 32'(OPC_HALT));

   assign hazard_s   = in_valid & ((ctrl_s[CTRL_USES_RS1]  & blk_rs1_s) |
                                   (ctrl_s[CTRL_USES_RS2]  & blk_rs2_s) |
                                   (ctrl_s[CTRL_REG_WRITE] & blk_rd_s));
   assign in_ready_s = ~flush & ~halted_q & ~hazard_s & (~out_valid_q | out_ready);
   assign accept_s   = in_valid & in_ready_s;
   assign busy_set_s = out_valid_q & out_ready & ~flush & out_ctrl_q[CTRL_REG_WRITE];

   decode_scoreboard #(.REG_W(REG_W)) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (busy_set_s),
      .set_rd  (out_rd_q),
      .clr_en  (wb_valid),
      .clr_rd  (wb_rd),
      .pend_en (out_valid_q & out_ctrl_q[CTRL_REG_WRITE]),
      .pend_rd (out_rd_q),
      .q_rs1   (rs1_s),
      .q_rs2   (rs2_s),
      .q_rd    (rd_s),
      .blk_rs1 (blk_rs1_s),
      .blk_rs2 (blk_rs2_s),
      .blk_rd  (blk_rd_s)
   );

   // Output register next state: accept loads, flush or drain empties, otherwise hold.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_opcode_d = out_opcode_q;
      out_rd_d     = out_rd_q;
      out_rs1_d    = out_rs1_q;
      out_rs2_d    = out_rs2_q;
      out_imm_d    = out_imm_q;
      out_ctrl_d   = out_ctrl_q;
      halted_d     = halted_q | (accept_s & is_halt_s);
      if (accept_s) begin
         out_valid_d  = 1'b1;
         out_opcode_d = opc_s;
         out_rd_d     = rd_s;
         out_rs1_d    = rs1_s;
         out_rs2_d    = rs2_s;
         out_imm_d    = imm_s;
         out_ctrl_d   = ctrl_s;
      end else if (flush || (out_valid_q && out_ready)) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output and halt registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         halted_q     <= 1'b0;
         out_opcode_q <= {OPC_W{1'b0}};
         out_rd_q     <= {REG_W{1'b0}};
         out_rs1_q    <= {REG_W{1'b0}};
         out_rs2_q    <= {REG_W{1'b0}};
         out_imm_q    <= {DATA_W{1'b0}};
         out_ctrl_q   <= {CTRL_W{1'b0}};
      end else begin
         out_valid_q  <= out_valid_d;
         halted_q     <= halted_d;
         out_opcode_q <= out_opcode_d;
         out_rd_q     <= out_rd_d;
         out_rs1_q    <= out_rs1_d;
         out_rs2_q    <= out_rs2_d;
         out_imm_q    <= out_imm_d;
         out_ctrl_q   <= out_ctrl_d;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_q;
   assign halted     = halted_q;
   assign out_opcode = out_opcode_q;
   assign out_rd     = out_rd_q;
   assign out_rs1    = out_rs1_q;
   assign out_rs2    = out_rs2_q;
   assign out_imm    = out_imm_q;
   assign out_ctrl   = out_ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a zero-extending and a sign-extending instance
// share one stimulus stream; every expected value is hand-computed.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready, wb_valid, flush;
   logic [15:0] in_instr;
   logic [1:0]  wb_rd;

   logic        in_ready, out_valid, halted;
   logic [3:0]  out_opcode;
   logic [1:0]  out_rd, out_rs1, out_rs2;
   logic [15:0] out_imm;
   logic [5:0]  out_ctrl;

   logic        sx_in_ready, sx_out_valid, sx_halted;
   logic [3:0]  sx_out_opcode;
   logic [1:0]  sx_out_rd, sx_out_rs1, sx_out_rs2;
   logic [15:0] sx_out_imm;
   logic [5:0]  sx_out_ctrl;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_stage #(.IMM_SEXT(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_ctrl(out_ctrl),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .halted(halted)
   );

   decode_stage #(.IMM_SEXT(1)) dut_sx (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(sx_in_ready),
      .out_valid(sx_out_valid), .out_ready(out_ready), .out_opcode(sx_out_opcode),
      .out_rd(sx_out_rd), .out_rs1(sx_out_rs1), .out_rs2(sx_out_rs2), .out_imm(sx_out_imm),
      .out_ctrl(sx_out_ctrl), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .halted(sx_halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b0;
      wb_valid = 1'b0; wb_rd = 2'd0; flush = 1'b0;
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_opcode", 32'(out_opcode), 32'd0);
      check("rst_imm", 32'(out_imm), 32'd0);
      check("rst_ctrl", 32'(out_ctrl), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: ADD r1,r2,r3
      in_valid = 1'b1; in_instr = 16'h16C0; out_ready = 1'b1;
      #1 check("add_in_ready", 32'(in_ready), 32'd1);
      step();
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_opcode", 32'(out_opcode), 32'd1);
      check("add_rd", 32'(out_rd), 32'd1);
      check("add_rs1", 32'(out_rs1), 32'd2);
      check("add_rs2", 32'(out_rs2), 32'd3);
      check("add_ctrl", 32'(out_ctrl), 32'h38);
      check("add_imm_zx", 32'(out_imm), 32'h00C0);
      check("add_imm_sx", 32'(sx_out_imm), 32'hFFC0);

      // 3: SUB r2,r1,r0 waits on r1
      in_instr = 16'h2900;
      #1 check("sub_stall_pend", 32'(in_ready), 32'd0);
      step();
      check("add_drained", 32'(out_valid), 32'd0);
      check("sub_stall_busy", 32'(in_ready), 32'd0);
      step();
      check("sub_stall_busy2", 32'(in_ready), 32'd0);
      wb_valid = 1'b1; wb_rd = 2'd1;
      #1 check("sub_wb_bypass", 32'(in_ready), 32'd1);
      step();
      wb_valid = 1'b0;
      check("sub_valid", 32'(out_valid), 32'd1);
      check("sub_opcode", 32'(out_opcode), 32'd2);
      check("sub_rd", 32'(out_rd), 32'd2);
      check("sub_rs1", 32'(out_rs1), 32'd1);
      check("sub_rs2", 32'(out_rs2), 32'd0);

      // 2: ADDI r0,0xF0
      in_instr = 16'h60F0;
      #1 check("addi_in_ready", 32'(in_ready), 32'd1);
      step();
      check("addi_opcode", 32'(out_opcode), 32'd6);
      check("addi_ctrl", 32'(out_ctrl), 32'h34);
      check("addi_imm_zx", 32'(out_imm), 32'h00F0);
      check("addi_imm_sx", 32'(sx_out_imm), 32'hFFF0);

      // 4: backpressure hold, then flush with out_ready high
      in_instr = 16'h7D55; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", 32'(in_ready), 32'd0);
         step();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_opcode", 32'(out_opcode), 32'd6);
         check("hold_imm", 32'(out_imm), 32'h00F0);
      end
      flush = 1'b1; out_ready = 1'b1;
      #1 check("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      in_instr = 16'h8400;
      #1 check("flush_r0_not_busy", 32'(in_ready), 32'd1);
      step();
      check("ld_opcode", 32'(out_opcode), 32'd8);
      check("ld_ctrl", 32'(out_ctrl), 32'h34);

      // 5: illegal opcode naming busy r2 never stalls, then HALT
      in_instr = 16'hDAAA;
      #1 check("ill_in_ready", 32'(in_ready), 32'd1);
      step();
      check("ill_opcode", 32'(out_opcode), 32'hD);
      check("ill_ctrl", 32'(out_ctrl), 32'h01);
      in_instr = 16'hF000;
      #1 check("halt_in_ready", 32'(in_ready), 32'd1);
      step();
      check("halt_opcode", 32'(out_opcode), 32'hF);
      check("halt_ctrl", 32'(out_ctrl), 32'h00);
      check("halted_set", 32'(halted), 32'd1);
      in_instr = 16'h0000;
      #1 check("halted_in_ready", 32'(in_ready), 32'd0);
      step();
      check("halt_drained", 32'(out_valid), 32'd0);
      step();
      check("halted_stays", 32'(halted), 32'd1);
      check("halted_in_ready2", 32'(in_ready), 32'd0);

      // 6: asynchronous reset while stalled with busy r1/r2
      in_instr = 16'h1D80;
      #1 check("pre_rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("arst_halted", 32'(halted), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_busy_clear", 32'(in_ready), 32'd1);
      #2 rst_n = 1'b1;
      step();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_opcode", 32'(out_opcode), 32'd1);
      check("post_rst_rd", 32'(out_rd), 32'd3);
      check("post_rst_rs1", 32'(out_rs1), 32'd1);
      check("post_rst_rs2", 32'(out_rs2), 32'd2);
      check("sx_halted_match", 32'(sx_halted), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
